axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 32-bit memory words (power of two).
REQ-002 Port aclk  input  1  single clock; all logic on posedge aclk.
REQ-003 Port arst  input  1  reset, asynchronous, active-high.
REQ-004 Ports awid[3:0], awaddr[31:0], awlen[3:0], awsize[2:0], awburst[1:0], awvalid  input; awready  output 1; write address channel.
REQ-005 Ports wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  input; wready  output 1; write data channel.
REQ-006 Ports bid[1:0], bresp[1:0], bvalid  output; bready  input; write response channel.
REQ-007 Ports arid[3:0], araddr[31:0], arlen[3:0], arsize[2:0], arburst[1:0], arvalid  input; arready  output 1; read address channel.
REQ-008 Ports rid[3:0], rdata[31:0], rlast, rresp[1:0], rvalid  output; rready  input; read data channel.

Function
REQ-009 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two run independently and concurrently.
REQ-010 awready = 1 only in W_IDLE; awvalid&awready captures id/addr/len/size/burst, beat count = 0, moves to W_DATA next cycle.
REQ-011 wready = 1 only in W_DATA; each wvalid&wready beat writes wdata bytes enabled by wstrb to mem[addr[log2(MEM_DEPTH)+1:2]] and advances address.
REQ-012 Final beat (beat count == awlen) moves to W_RESP; wlast not asserted on final beat, or asserted earlier, latches error SLVERR; burst ends only on count.
REQ-013 W_RESP: bvalid = 1, bid = captured awid[1:0], bresp = OKAY(0) or SLVERR(2); held until bready, then W_IDLE next cycle.
REQ-014 arready = 1 only in R_IDLE; arvalid&arready captures request and moves to R_DATA with first beat presented the next cycle.
REQ-015 R_DATA: rvalid = 1, rid = captured arid, rdata registered from memory when beat is loaded and held stable while rready = 0; rlast = 1 on beat arlen only.
REQ-016 rvalid&rready advances to the next beat (loaded next cycle, no bubble); on the last beat returns to R_IDLE.
REQ-017 Burst address: FIXED(0) constant; INCR(1) +4 per beat; WRAP(2) +4 wrapping at boundary aligned to (len+1)*4 bytes.
REQ-018 Errors giving SLVERR for whole burst: size != 2, burst = 3, WRAP with len not in {1,3,7,15}, address beyond MEM_DEPTH*4; erroneous write beats do not update memory; erroneous read beats return rdata = 0.
REQ-019 rresp = OKAY or SLVERR per the captured request.
REQ-020 Memory index uses address bits [log2(MEM_DEPTH)+1:2]; bits [1:0] ignored.
REQ-021 Same-cycle write beat and read beat load to same word: read returns pre-write data.

Reset
REQ-022 arst asserted: FSMs to W_IDLE/R_IDLE immediately; awready, wready, arready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
REQ-023 Reset mid-burst abandons the burst with no response; memory contents are not cleared.
REQ-024 First cycle after deassertion: awready = arready = 1.

Configuration
REQ-025 Macro AXI_SLV_WID_CHECK_EN defined: a write beat with wid != captured awid forces bresp = SLVERR and that beat is not written; undefined: wid ignored.

Structure
REQ-026 Package axi_slv_pkg holds burst-type enum, response constants (OKAY, SLVERR), write/read FSM state enums.
REQ-027 Sub-module axi_burst_addr (current address, len, burst -> next address) instantiated once per FSM.

Verification
REQ-028 INCR write awaddr=0x10 awlen=3 data 1..4 strb 0xF, then read same -> bresp=0, bid=awid[1:0], rdata 1,2,3,4, rlast on beat 4.
REQ-029 WRAP read araddr=0x18 arlen=3 -> addresses 0x18,0x1C,0x10,0x14.
REQ-030 Read with rready low for 3 cycles mid-burst -> rdata/rvalid/rlast stable, no beat lost.
REQ-031 awsize=1 write, or awaddr=MEM_DEPTH*4 -> bresp=2, memory unchanged on readback.
REQ-032 wstrb=0x3 write 0xAABBCCDD over 0x11223344 -> readback 0x1122CCDD.
REQ-033 arst asserted in W_DATA beat 2 -> bvalid never asserts, awready=1 after release, earlier beats retained.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI slave memory: burst encodings, response codes,
// FSM state enums, the captured-request record and the request check.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Request captured on an address handshake; addr advances per beat.
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic        err;
    } req_t;

    // A request is rejected as a whole if its size/burst/len combination is
    // unsupported or any beat would land outside the memory (limit in bytes).
    // Only INCR moves past the start word; WRAP stays inside its aligned
    // window, which lies below the limit whenever the start address does.
    function automatic logic req_err(input logic [31:0] addr,
                                     input logic [3:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input logic [32:0] limit);
        logic [32:0] last;
        logic        bad_wrap;
        last = {1'b0, addr};
        if (burst == BURST_INCR) last = last + {27'd0, len, 2'b00};
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size != 3'd2) || (burst == BURST_RSVD) || bad_wrap ||
               ({1'b0, addr} >= limit) || (last >= limit);
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI3-style bus bundle between a master and the slave memory.
interface axi_slave_mem_if;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rresp, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rresp, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Next-beat address for 4-byte beats: FIXED holds, INCR adds 4, WRAP adds 4
// inside a window of (len+1)*4 bytes aligned to its own size.
module axi_burst_addr
    import axi_slv_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [3:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_o
);

    logic [31:0] incr;
    logic [31:0] wrap_mask;

    assign incr      = addr_i + 32'd4;
    assign wrap_mask = {25'd0, ({1'b0, len_i} + 5'd1), 2'b00} - 32'd1;

    // Select the address of the following beat from the burst type.
    always_comb begin
        next_o = addr_i;
        case (burst_i)
            BURST_INCR: next_o = incr;
            BURST_WRAP: next_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default:    next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// Word-addressed AXI slave memory with independent write and read FSMs.
// Optional macro AXI_SLV_WID_CHECK_EN: a write beat whose wid differs from
// the captured awid is dropped and the burst answers SLVERR.
module axi_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int MEM_DEPTH = 256
)(
    input  logic           aclk,
    input  logic           arst,
    axi_slave_mem_if.slave bus
);

    localparam int          IW        = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

    logic [31:0] mem_q [MEM_DEPTH];

    w_state_e    w_state_q;
    req_t        aw_q;
    logic [3:0]  w_cnt_q;
    logic        w_err_q;     // sticky wlast/wid protocol error within a burst
    logic [1:0]  bid_q;
    logic [1:0]  bresp_q;

    r_state_e    r_state_q;
    req_t        ar_q;
    logic [3:0]  r_cnt_q;
    logic [31:0] rdata_q;
    logic        rlast_q;

    logic [31:0] w_next;
    logic [31:0] r_next;
    logic        aw_err;
    logic        ar_err;
    logic        w_final;
    logic        wlast_bad;
    logic        wid_bad;
    logic        w_wen;
    logic [IW-1:0] w_idx;
    logic [31:0] r_load_addr;
    logic [IW-1:0] r_idx;

    axi_burst_addr u_w_addr (
        .addr_i  (aw_q.addr),
        .len_i   (aw_q.len),
        .burst_i (aw_q.burst),
        .next_o  (w_next)
    );

    axi_burst_addr u_r_addr (
        .addr_i  (ar_q.addr),
        .len_i   (ar_q.len),
        .burst_i (ar_q.burst),
        .next_o  (r_next)
    );

    assign aw_err = req_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst, MEM_BYTES);
    assign ar_err = req_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst, MEM_BYTES);

`ifdef AXI_SLV_WID_CHECK_EN
    assign wid_bad = (bus.wid != aw_q.id);
`else
    logic unused_wid;
    assign wid_bad    = 1'b0;
    assign unused_wid = ^{bus.wid, aw_q.id[3:2]};
`endif

    // Burst length is governed by the beat count; wlast only flags errors.
    assign w_final   = (w_cnt_q == aw_q.len);
    assign wlast_bad = (bus.wlast != w_final);
    assign w_wen     = (w_state_q == W_DATA) && bus.wvalid && !aw_q.err && !wid_bad;
    assign w_idx     = aw_q.addr[IW+1:2];

    // First beat comes from the incoming request, later beats from the
    // burst address generator.
    assign r_load_addr = (r_state_q == R_IDLE) ? bus.araddr : r_next;
    assign r_idx       = r_load_addr[IW+1:2];

    // Address-channel readies gated by arst so nothing is accepted in reset.
    assign bus.awready = (w_state_q == W_IDLE) && !arst;
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    assign bus.arready = (r_state_q == R_IDLE) && !arst;
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rid     = ar_q.id;
    assign bus.rdata   = rdata_q;
    assign bus.rlast   = rlast_q;
    assign bus.rresp   = ar_q.err ? RESP_SLVERR : RESP_OKAY;

    // Byte-enabled memory write; no reset so contents survive arst.
    always_ff @(posedge aclk) begin
        if (w_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem_q[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // Write FSM: accept address, count data beats, hold response until bready.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            w_state_q <= W_IDLE;
            aw_q      <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (bus.awvalid) begin
                        aw_q <= '{id: bus.awid, addr: bus.awaddr, len: bus.awlen,
                                  burst: bus.awburst, err: aw_err};
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid) begin
                        aw_q.addr <= w_next;
                        w_cnt_q   <= w_cnt_q + 4'd1;
                        if (w_final) begin
                            bid_q     <= aw_q.id[1:0];
                            bresp_q   <= (aw_q.err || w_err_q || wlast_bad || wid_bad)
                                         ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else if (wlast_bad || wid_bad) begin
                            w_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: load a beat on accept and on every taken beat, so rdata is
    // registered, stable under backpressure and streams without bubbles.
    // The memory is read here before this cycle's write lands, so a
    // colliding write is seen by the next load, not this one.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state_q <= R_IDLE;
            ar_q      <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else if (r_state_q == R_IDLE) begin
            if (bus.arvalid) begin
                ar_q <= '{id: bus.arid, addr: bus.araddr, len: bus.arlen,
                          burst: bus.arburst, err: ar_err};
                r_cnt_q   <= '0;
                rdata_q   <= ar_err ? 32'd0 : mem_q[r_idx];
                rlast_q   <= (bus.arlen == 4'd0);
                r_state_q <= R_DATA;
            end
        end else if (bus.rready) begin
            if (rlast_q) begin
                rlast_q   <= 1'b0;
                r_state_q <= R_IDLE;
            end else begin
                ar_q.addr <= r_next;
                r_cnt_q   <= r_cnt_q + 4'd1;
                rdata_q   <= ar_q.err ? 32'd0 : mem_q[r_idx];
                rlast_q   <= ((r_cnt_q + 4'd1) == ar_q.len);
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, wrap, backpressure, errors, reset.
module tb_axi_slave_mem;

    logic aclk = 1'b0;
    logic arst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    axi_slave_mem_if bus();

    axi_slave_mem #(.MEM_DEPTH(256)) dut (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                            input logic [3:0] strb, input int last_at, input int abort_at,
                            output logic [1:0] resp, output logic [1:0] bidv);
        int k;
        resp = 2'bxx;
        bidv = 2'bxx;
        @(negedge aclk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        k = 0;
        while (!bus.awready && k < 20) begin @(negedge aclk); k++; end
        chk("aw_handshake", 32'(bus.awready), 32'd1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                bus.wvalid = 1'b0;
                return;
            end
            bus.wdata = base + 32'(i); bus.wstrb = strb; bus.wid = id;
            bus.wlast = (i == last_at); bus.wvalid = 1'b1;
            k = 0;
            while (!bus.wready && k < 20) begin @(negedge aclk); k++; end
            @(negedge aclk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        k = 0;
        while (!bus.bvalid && k < 20) begin @(negedge aclk); k++; end
        chk("b_handshake", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        bidv = bus.bid;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    // exp holds up to four beats, beat 0 in the low word.
    task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst, input logic [1:0] exp_resp,
                           input logic [3:0][31:0] exp, input int stall_at);
        int k;
        @(negedge aclk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
        bus.arburst = burst; bus.arvalid = 1'b1;
        k = 0;
        while (!bus.arready && k < 20) begin @(negedge aclk); k++; end
        chk({tag, "_ar_handshake"}, 32'(bus.arready), 32'd1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
            chk({tag, "_rdata"}, bus.rdata, exp[i]);
            chk({tag, "_rlast"}, 32'(bus.rlast), 32'(i == int'(len)));
            chk({tag, "_rid"}, 32'(bus.rid), 32'(id));
            chk({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
            if (i == stall_at) begin
                bus.rready = 1'b0;
                repeat (3) begin
                    @(negedge aclk);
                    chk({tag, "_stall_rdata"}, bus.rdata, exp[i]);
                    chk({tag, "_stall_rvalid"}, 32'(bus.rvalid), 32'd1);
                    chk({tag, "_stall_rlast"}, 32'(bus.rlast), 32'(i == int'(len)));
                end
            end
            bus.rready = 1'b1;
            @(negedge aclk);
            bus.rready = 1'b0;
        end
        chk({tag, "_rvalid_done"}, 32'(bus.rvalid), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] resp;
        logic [1:0] bidv;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_bresp_bid", 32'({bus.bresp, bus.bid}), 32'd0);
        chk("rst_rid_rresp", 32'({bus.rid, bus.rresp}), 32'd0);
        arst = 1'b0;
        #1;
        chk("post_rst_awready", 32'(bus.awready), 32'd1);
        chk("post_rst_arready", 32'(bus.arready), 32'd1);

        // INCR write 1..4 at 0x10, then read back
        do_write(4'hD, 32'h10, 4'd3, 3'd2, 2'd1, 32'd1, 4'hF, 3, -1, resp, bidv);
        chk("incr_bresp", 32'(resp), 32'd0);
        chk("incr_bid", 32'(bidv), 32'd1);
        do_read("incr", 4'h6, 32'h10, 4'd3, 2'd1, 2'd0, {32'd4, 32'd3, 32'd2, 32'd1}, -1);

        // Backpressure on beat 1 for three cycles
        do_read("stall", 4'h9, 32'h10, 4'd3, 2'd1, 2'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 1);

        // WRAP read from 0x18 over words 0x10..0x1C
        do_write(4'h2, 32'h10, 4'd3, 3'd2, 2'd1, 32'h100, 4'hF, 3, -1, resp, bidv);
        chk("wrap_fill_bresp", 32'(resp), 32'd0);
        chk("wrap_fill_bid", 32'(bidv), 32'd2);
        do_read("wrap", 4'h3, 32'h18, 4'd3, 2'd2, 2'd0,
                {32'h101, 32'h100, 32'h103, 32'h102}, -1);

        // awsize=1 is rejected and leaves memory untouched
        do_write(4'h1, 32'h10, 4'd3, 3'd1, 2'd1, 32'hDEAD0000, 4'hF, 3, -1, resp, bidv);
        chk("size_bresp", 32'(resp), 32'd2);
        do_read("size_keep", 4'h1, 32'h10, 4'd3, 2'd1, 2'd0,
                {32'h103, 32'h102, 32'h101, 32'h100}, -1);

        // Address at MEM_DEPTH*4 is rejected; word 0 (its alias) is kept
        do_write(4'h0, 32'h0, 4'd0, 3'd2, 2'd1, 32'h55, 4'hF, 0, -1, resp, bidv);
        chk("word0_bresp", 32'(resp), 32'd0);
        do_write(4'h0, 32'h400, 4'd0, 3'd2, 2'd1, 32'h66, 4'hF, 0, -1, resp, bidv);
        chk("oob_bresp", 32'(resp), 32'd2);
        do_read("oob_keep", 4'h0, 32'h0, 4'd0, 2'd1, 2'd0, {32'd0, 32'd0, 32'd0, 32'h55}, -1);
        do_read("oob_read", 4'h5, 32'h400, 4'd0, 2'd1, 2'd2, {32'd0, 32'd0, 32'd0, 32'd0}, -1);

        // Partial strobe merge
        do_write(4'h4, 32'h40, 4'd0, 3'd2, 2'd1, 32'h11223344, 4'hF, 0, -1, resp, bidv);
        chk("strb_base_bresp", 32'(resp), 32'd0);
        do_write(4'h4, 32'h40, 4'd0, 3'd2, 2'd1, 32'hAABBCCDD, 4'h3, 0, -1, resp, bidv);
        chk("strb_bresp", 32'(resp), 32'd0);
        do_read("strb", 4'h4, 32'h40, 4'd0, 2'd1, 2'd0, {32'd0, 32'd0, 32'd0, 32'h1122CCDD}, -1);

        // wlast early / missing gives SLVERR
        do_write(4'h7, 32'h50, 4'd1, 3'd2, 2'd1, 32'h0, 4'hF, 0, -1, resp, bidv);
        chk("wlast_early_bresp", 32'(resp), 32'd2);
        chk("wlast_early_bid", 32'(bidv), 32'd3);
        do_write(4'h7, 32'h50, 4'd0, 3'd2, 2'd1, 32'h0, 4'hF, -1, -1, resp, bidv);
        chk("wlast_missing_bresp", 32'(resp), 32'd2);

        // FIXED burst hits one word
        do_write(4'h8, 32'h60, 4'd1, 3'd2, 2'd0, 32'hA0, 4'hF, 1, -1, resp, bidv);
        chk("fixed_bresp", 32'(resp), 32'd0);
        do_read("fixed", 4'h8, 32'h60, 4'd1, 2'd0, 2'd0, {32'd0, 32'd0, 32'hA1, 32'hA1}, -1);

        // WRAP with len=2 and reserved burst type are rejected with zero data
        do_read("wrap_len2", 4'hA, 32'h10, 4'd2, 2'd2, 2'd2, {32'd0, 32'd0, 32'd0, 32'd0}, -1);
        do_read("burst3", 4'hB, 32'h10, 4'd0, 2'd3, 2'd2, {32'd0, 32'd0, 32'd0, 32'd0}, -1);

        // Reset in the middle of a write burst (before beat 2)
        do_write(4'hC, 32'h80, 4'd3, 3'd2, 2'd1, 32'h70, 4'hF, 3, 2, resp, bidv);
        arst = 1'b1;
        #1;
        chk("midrst_awready", 32'(bus.awready), 32'd0);
        chk("midrst_wready", 32'(bus.wready), 32'd0);
        chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
        @(negedge aclk);
        arst = 1'b0;
        #1;
        chk("midrst_awready_after", 32'(bus.awready), 32'd1);
        repeat (4) begin
            @(negedge aclk);
            chk("midrst_no_bvalid", 32'(bus.bvalid), 32'd0);
        end
        do_read("midrst_keep", 4'hC, 32'h80, 4'd1, 2'd1, 2'd0, {32'd0, 32'd0, 32'h71, 32'h70}, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
